// File: rtl/program_sequencer.sv
// Batch launcher for the core's start/done handshake: runs a latched list of programs
// back-to-back, measures each program's cycle count, with watchdog timeout and abort.
module program_sequencer #(
    parameter int ADDR_W = 8,
    parameter int N_PROGS = 4,
    parameter int CNT_W = 16,
    localparam int IDX_W = $clog2(N_PROGS + 1)
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      run_i,
    input  logic [IDX_W-1:0]          prog_count_i,
    input  logic [N_PROGS*ADDR_W-1:0] prog_addr_i,
    input  logic [CNT_W-1:0]          timeout_i,
    input  logic                      abort_i,
    output logic                      cpu_start_o,
    output logic [ADDR_W-1:0]         cpu_start_addr_o,
    input  logic                      cpu_done_i,
    output logic                      busy_o,
    output logic [IDX_W-1:0]          prog_idx_o,
    output logic [CNT_W-1:0]          cyc_count_o,
    output logic                      cyc_valid_o,
    output logic                      batch_done_o,
    output logic                      timeout_o
);
    // state  | meaning
    // IDLE   | waiting for run_i
    // START  | start pulse to core, counter loaded with 1
    // SETTLE | stale done from the previous run is masked
    // WAIT   | waiting for done or watchdog
    // NEXT   | advance to next program or finish
    // FINISH | batch_done pulse
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    logic [2:0]                state;
    logic [N_PROGS*ADDR_W-1:0] addr_list;
    logic [IDX_W-1:0]          count;
    logic [IDX_W-1:0]          idx;
    logic [IDX_W-1:0]          idx_next;
    logic [IDX_W-1:0]          count_sat;
    logic [CNT_W-1:0]          cnt;
    logic [ADDR_W-1:0]         addr_sel;

    assign idx_next     = idx + IDX_W'(1);
    assign count_sat    = (prog_count_i > IDX_W'(N_PROGS)) ? IDX_W'(N_PROGS) : prog_count_i;
    assign cpu_start_o  = (state == S_START);
    assign busy_o       = (state != S_IDLE);
    assign batch_done_o = (state == S_FINISH);
    assign prog_idx_o   = idx;

    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < N_PROGS; k++) begin
            if (idx_next == IDX_W'(k)) addr_sel = addr_list[k*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state            <= S_IDLE;
            addr_list        <= '0;
            count            <= '0;
            idx              <= '0;
            cnt              <= '0;
            cpu_start_addr_o <= '0;
            cyc_count_o      <= '0;
            cyc_valid_o      <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            cyc_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run_i) begin
                        addr_list <= prog_addr_i;
                        count     <= count_sat;
                        idx       <= '0;
                        timeout_o <= 1'b0;
                        if (count_sat != '0) begin
                            // address is loaded on entry so it is valid alongside the pulse
                            cpu_start_addr_o <= prog_addr_i[ADDR_W-1:0];
                            state            <= S_START;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_START: begin
                    cnt   <= CNT_W'(1);
                    state <= abort_i ? S_FINISH : S_SETTLE;
                end
                S_SETTLE: begin
                    cnt   <= cnt + CNT_W'(1);
                    state <= abort_i ? S_FINISH : S_WAIT;
                end
                S_WAIT: begin
                    if (abort_i) begin
                        state <= S_FINISH;
                    end else if (cpu_done_i) begin
                        cyc_count_o <= cnt;
                        cyc_valid_o <= 1'b1;
                        state       <= S_NEXT;
                    end else if (timeout_i != '0 && cnt == timeout_i) begin
                        timeout_o <= 1'b1;
                        state     <= S_FINISH;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (abort_i || idx_next == count) begin
                        state <= S_FINISH;
                    end else begin
                        idx              <= idx_next;
                        cpu_start_addr_o <= addr_sel;
                        state            <= S_START;
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule
